// File: rtl/iomem_cmd_master.sv
// iomem_cmd_master: byte-framed host command bridge issuing single PicoSoC iomem transactions
module iomem_cmd_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ADDR, STRB, DATA, BUS, RESP, RDAT} state_t;
  state_t state, state_nx;
  logic is_wr;
  logic [1:0] bcnt;
  logic [15:0] tcnt;
  logic [31:0] rsh;
  logic rx_fire, tx_fire, limit;
  assign rx_fire = rx_valid & rx_ready;
  assign tx_fire = tx_valid & tx_ready;
  assign limit = tcnt == 16'(TIMEOUT_CYCLES - 1);
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  // next-state decode; a ready on the timeout cycle takes priority over the abort
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (rx_fire) state_nx = (rx_data == 8'h57 || rx_data == 8'h52) ? ADDR : RESP;
      ADDR: if (rx_fire && bcnt == 2'd3) state_nx = is_wr ? STRB : BUS;
      STRB: if (rx_fire) state_nx = DATA;
      DATA: if (rx_fire && bcnt == 2'd3) state_nx = BUS;
      BUS:  if (iomem_ready || limit) state_nx = RESP;
      RESP: if (tx_fire) state_nx = (!is_wr && tx_data == 8'h00) ? RDAT : IDLE;
      RDAT: if (tx_fire && bcnt == 2'd3) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // registered handshakes, frame field capture, bus timeout and response byte sequencing
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rx_ready <= 1'b0;
      tx_valid <= 1'b0;
      tx_data <= 8'h00;
      iomem_valid <= 1'b0;
      iomem_wstrb <= 4'h0;
      iomem_addr <= 32'h0;
      iomem_wdata <= 32'h0;
      is_wr <= 1'b0;
      bcnt <= 2'd0;
      tcnt <= 16'd0;
      rsh <= 32'h0;
    end else begin
      rx_ready <= state_nx inside {IDLE, ADDR, STRB, DATA};
      tx_valid <= state_nx inside {RESP, RDAT};
      iomem_valid <= state_nx == BUS;
      tcnt <= (state == BUS) ? tcnt + 16'd1 : 16'd0;
      if ((rx_fire && (state == ADDR || state == DATA)) || (tx_fire && state == RDAT)) bcnt <= bcnt + 2'd1;
      if (rx_fire && state == IDLE) begin
        is_wr <= rx_data == 8'h57;
        iomem_wstrb <= 4'h0;
      end
      if (rx_fire && state == ADDR) iomem_addr <= {iomem_addr[23:0], rx_data};
      if (rx_fire && state == STRB) iomem_wstrb <= rx_data[3:0];
      if (rx_fire && state == DATA) iomem_wdata <= {iomem_wdata[23:0], rx_data};
      if (state == BUS && iomem_ready) rsh <= iomem_rdata;
      if (state != RESP && state_nx == RESP)
        tx_data <= (state == IDLE) ? 8'h3F : iomem_ready ? 8'h00 : 8'hEE;
      else if (tx_fire && state_nx == RDAT) begin
        tx_data <= rsh[31:24];
        rsh <= {rsh[23:0], 8'h00};
      end
    end
endmodule

// File: doc/iomem_cmd_master.md
# iomem_cmd_master

Byte-stream command bridge that acts as an initiator on the PicoSoC iomem bus. It turns framed commands arriving on an 8-bit valid/ready input into single iomem read or write transactions, and returns status and read data on an 8-bit valid/ready output. It sits between a host-facing byte transport (UART or debug link) and the board-level iomem peripheral decode. This gives an external host direct access to the gpio, mmio and fp_gpio register windows.

## Interface
- TIMEOUT_CYCLES, 255: maximum bus cycles to wait for iomem_ready before abort (1..65535).
- clk  in  1  system clock; all logic rising-edge.
- resetn  in  1  asynchronous active-low reset.
- rx_valid  in  1  command byte present.
- rx_data  in  8  command byte.
- rx_ready  out  1  bridge accepts rx_data this cycle.
- tx_valid  out  1  response byte present.
- tx_data  out  8  response byte.
- tx_ready  in  1  sink accepts tx_data this cycle.
- iomem_valid  out  1  transaction request.
- iomem_ready  in  1  responder completion, single-cycle pulse.
- iomem_wstrb  out  4  byte write strobes; 0 = read.
- iomem_addr  out  32  transaction address.
- iomem_wdata  out  32  write data.
- iomem_rdata  in  32  read data, valid when iomem_ready=1.
- busy  out  1  high in any state other than IDLE.

## Operation
- Frames, multi-byte fields MSB first:
  - write = 0x57, addr[4], strb[1] (bits 3:0 used, 7:4 ignored), data[4];
  - read = 0x52, addr[4].
- Responses:
  - write → one status byte;
  - read → status byte, then 4 data bytes MSB first, only when status is OK.
- Status codes: 0x00 OK, 0xEE timeout, 0x3F unknown opcode (unknown opcode returns to IDLE after sending 0x3F).
- A read with a timeout status sends no data bytes.
- States:
  - IDLE → OPC decode;
  - ADDR (4 bytes) → STRB (write only) → DATA (4 bytes, write only) → BUS → RESP → RDAT (read OK only) → IDLE.
- A read has wstrb forced to 4'b0000.
- A write with strb=0 is still issued as a write frame, with iomem_wstrb=0. The responder treats it as a read, and the returned data is discarded.
- Byte counter: 2 bits, wraps 3→0 on the transition out of ADDR/DATA/RDAT.
- In BUS:
  - iomem_valid=1; addr, wdata and wstrb are held stable until the ready cycle.
  - A 16-bit timeout counter is cleared on BUS entry and increments each cycle with iomem_ready=0.
  - When the count reaches TIMEOUT_CYCLES, the state goes to RESP with status 0xEE.
  - iomem_ready in the same cycle the limit is hit wins: status OK.
- Read data is captured into a 32-bit shift register in the iomem_ready cycle.
- rx_ready=1 only in IDLE/ADDR/STRB/DATA; bytes are never dropped or buffered beyond the current field.
- Reset mid-frame or mid-transaction:
  - all state is abandoned; iomem_valid drops immediately (asynchronously);
  - no response is sent; the partial frame is discarded.

## Timing
- Reset values:
  - rx_ready=0, tx_valid=0, tx_data=0x00;
  - iomem_valid=0, iomem_addr=0, iomem_wdata=0, iomem_wstrb=0;
  - busy=0.
- rx_ready rises the first cycle after resetn deasserts.
- rx_ready is a registered output and is low during BUS/RESP/RDAT.
- Byte accepted on the rising edge with rx_valid&rx_ready.
- iomem_valid rises on the cycle after the last frame byte is accepted.
- iomem_valid falls on the cycle after iomem_ready=1 is sampled, so it is never high in two consecutive transactions without a gap.
- Latency, last rx byte to first tx_valid, = 2 + responder latency:
  - responder ready at cycle N after valid → tx_valid at N+1.
- tx_valid holds, with tx_data stable, until tx_ready.
- The next response byte is presented the cycle after the handshake, with no bubble.
- After the final tx handshake, the state returns to IDLE and rx_ready=1 on the next cycle.
- Timeout abort: with no ready, iomem_valid is high for exactly TIMEOUT_CYCLES cycles.

## Test plan
- Write 0x57,03 00 00 00,0F,00 00 00 A5 with responder ready 2 cycles after valid:
  - iomem_addr=0x03000000, wdata=0x000000A5, wstrb=4'hF, valid high 2 cycles;
  - tx 0x00.
- Read 0x52,06 00 00 00 with responder returning 0x00000003:
  - wstrb=0;
  - tx 0x00,00,00,00,03.
- Read with responder never ready, TIMEOUT_CYCLES=8:
  - iomem_valid high exactly 8 cycles, then low;
  - tx 0xEE only; busy low afterwards.
- Opcode 0x41 → tx 0x3F, no iomem_valid, then a following valid read completes normally.
- tx_ready held low 10 cycles during a read response: tx_data stable, no byte lost, 5 bytes in order.
- resetn pulsed low during BUS → iomem_valid 0 at once; no tx; the next write frame completes with 0x00.
